// File: rtl/fx_master.sv
// fx_master: initiator side of the fx register bus.
// Converts upstream burst commands into fx write strobes or fx read
// request/response sequences, returning read bytes on a valid/ready stream.
module fx_master #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic        wd_vld,
  output logic        wd_rdy,
  input  logic [7:0]  wd_data,
  output logic        rd_vld,
  input  logic        rd_rdy,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic        cmd_done,
  output logic        fx_wr,
  output logic [15:0] fx_waddr,
  output logic [7:0]  fx_data,
  output logic        fx_rd,
  output logic [15:0] fx_raddr,
  input  logic [7:0]  fx_q
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_REQ,
    RD_WAIT,
    RD_RSP
  } state_t;

  // Wait-counter value on the edge where the slave data is valid.
  localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] addr;
  logic [7:0]  len;
  logic [7:0]  beat;
  logic [3:0]  lat_cnt;
  logic        cmd_hs;
  logic        wd_hs;
  logic        rd_hs;
  logic        last_beat;
  logic        lat_done;

  assign busy = (state != IDLE);

  // Next-state selection plus the ready outputs and handshake qualifiers.
  always_comb begin
    state_next = state;
    cmd_rdy    = 1'b0;
    wd_rdy     = 1'b0;
    cmd_hs     = 1'b0;
    wd_hs      = 1'b0;
    rd_hs      = 1'b0;
    last_beat  = (beat == len);
    lat_done   = (lat_cnt == LAT_LAST);
    case (state)
      IDLE: begin
        cmd_rdy = !rst;
        cmd_hs  = cmd_vld && !rst;
        if (cmd_hs) begin
          state_next = cmd_wr ? WR : RD_REQ;
        end
      end
      WR: begin
        wd_rdy = !rst;
        wd_hs  = wd_vld && !rst;
        if (wd_hs && last_beat) begin
          state_next = IDLE;
        end
      end
      RD_REQ: begin
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat_done) begin
          state_next = RD_RSP;
        end
      end
      RD_RSP: begin
        rd_hs = rd_vld && rd_rdy;
        if (rd_hs) begin
          state_next = last_beat ? IDLE : RD_REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: fx_rd is raised on the edge entering RD_REQ so that the
  // strobe coincides with RD_REQ and read beats can repeat every RD_LAT+2.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      addr     <= 16'd0;
      len      <= 8'd0;
      beat     <= 8'd0;
      lat_cnt  <= 4'd0;
      fx_wr    <= 1'b0;
      fx_waddr <= 16'd0;
      fx_data  <= 8'd0;
      fx_rd    <= 1'b0;
      fx_raddr <= 16'd0;
      rd_vld   <= 1'b0;
      rd_data  <= 8'd0;
      cmd_done <= 1'b0;
    end else begin
      fx_wr    <= 1'b0;
      fx_rd    <= 1'b0;
      cmd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_hs) begin
            len  <= cmd_len;
            beat <= 8'd0;
            if (cmd_wr) begin
              addr <= cmd_addr;
            end else begin
              fx_rd    <= 1'b1;
              fx_raddr <= cmd_addr;
              addr     <= cmd_addr + 16'd1;
            end
          end
        end
        WR: begin
          if (wd_hs) begin
            fx_wr    <= 1'b1;
            fx_waddr <= addr;
            fx_data  <= wd_data;
            addr     <= addr + 16'd1;
            beat     <= beat + 8'd1;
            cmd_done <= last_beat;
          end
        end
        RD_REQ: begin
          lat_cnt <= 4'd0;
        end
        RD_WAIT: begin
          if (lat_done) begin
            rd_data <= fx_q;
            rd_vld  <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        RD_RSP: begin
          if (rd_hs) begin
            rd_vld <= 1'b0;
            if (last_beat) begin
              cmd_done <= 1'b1;
            end else begin
              beat     <= beat + 8'd1;
              fx_rd    <= 1'b1;
              fx_raddr <= addr;
              addr     <= addr + 16'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx_master.sv
// tb_fx_master: directed and randomized checks of fx_master against a
// behavioural slave and expected-value arithmetic kept in the bench.
module tb_fx_master;

  localparam int RD_LAT = 2;

  logic        clk_sys  = 1'b0;
  logic        rst      = 1'b1;
  logic        cmd_vld  = 1'b0;
  logic        cmd_rdy;
  logic        cmd_wr   = 1'b0;
  logic [15:0] cmd_addr = 16'd0;
  logic [7:0]  cmd_len  = 8'd0;
  logic        wd_vld   = 1'b0;
  logic        wd_rdy;
  logic [7:0]  wd_data  = 8'd0;
  logic        rd_vld;
  logic        rd_rdy   = 1'b0;
  logic [7:0]  rd_data;
  logic        busy;
  logic        cmd_done;
  logic        fx_wr;
  logic [15:0] fx_waddr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [15:0] fx_raddr;
  logic [7:0]  fx_q;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] wrData [$];

  fx_master #(.RD_LAT(RD_LAT)) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .cmd_vld (cmd_vld),
    .cmd_rdy (cmd_rdy),
    .cmd_wr  (cmd_wr),
    .cmd_addr(cmd_addr),
    .cmd_len (cmd_len),
    .wd_vld  (wd_vld),
    .wd_rdy  (wd_rdy),
    .wd_data (wd_data),
    .rd_vld  (rd_vld),
    .rd_rdy  (rd_rdy),
    .rd_data (rd_data),
    .busy    (busy),
    .cmd_done(cmd_done),
    .fx_wr   (fx_wr),
    .fx_waddr(fx_waddr),
    .fx_data (fx_data),
    .fx_rd   (fx_rd),
    .fx_raddr(fx_raddr),
    .fx_q    (fx_q)
  );

  always #5 clk_sys = ~clk_sys;

  // Slave register contents as seen by a read of a given address.
  function automatic logic [7:0] slaveByte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Slave model: fx_q is valid exactly RD_LAT cycles after fx_rd, junk otherwise.
  logic        pipeVld  [RD_LAT] = '{default: 1'b0};
  logic [15:0] pipeAddr [RD_LAT] = '{default: 16'd0};
  logic [7:0]  junk = 8'd0;

  always @(posedge clk_sys) begin
    pipeVld[0]  <= fx_rd;
    pipeAddr[0] <= fx_raddr;
    for (int i = 1; i < RD_LAT; i++) begin
      pipeVld[i]  <= pipeVld[i-1];
      pipeAddr[i] <= pipeAddr[i-1];
    end
  end

  // Fresh junk byte every cycle so mistimed sampling shows up.
  always @(negedge clk_sys) junk <= 8'($urandom);

  assign fx_q = pipeVld[RD_LAT-1] ? slaveByte(pipeAddr[RD_LAT-1]) : junk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_cmd_rdy"},  32'(cmd_rdy),  32'd0);
    checkOutput({pfx, "_wd_rdy"},   32'(wd_rdy),   32'd0);
    checkOutput({pfx, "_rd_vld"},   32'(rd_vld),   32'd0);
    checkOutput({pfx, "_rd_data"},  32'(rd_data),  32'd0);
    checkOutput({pfx, "_busy"},     32'(busy),     32'd0);
    checkOutput({pfx, "_cmd_done"}, 32'(cmd_done), 32'd0);
    checkOutput({pfx, "_fx_wr"},    32'(fx_wr),    32'd0);
    checkOutput({pfx, "_fx_waddr"}, 32'(fx_waddr), 32'd0);
    checkOutput({pfx, "_fx_data"},  32'(fx_data),  32'd0);
    checkOutput({pfx, "_fx_rd"},    32'(fx_rd),    32'd0);
    checkOutput({pfx, "_fx_raddr"}, 32'(fx_raddr), 32'd0);
  endtask

  // Present a command and wait until it is accepted on the next rising edge.
  task automatic applyStimulus(input logic wr, input logic [15:0] a, input logic [7:0] l);
    int n;
    @(negedge clk_sys);
    cmd_vld  = 1'b1;
    cmd_wr   = wr;
    cmd_addr = a;
    cmd_len  = l;
    n = 0;
    while (!cmd_rdy && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput("cmd_accept_in_time", 32'(n < 400), 32'd1);
  endtask

  // Feed l+1 write bytes; each must appear on fx one cycle after its handshake.
  task automatic writeBeats(input logic [15:0] a, input logic [7:0] l, input int gapAt,
                            input int gapLen, input int maxRandGap, input bit holdCmd,
                            input logic [15:0] holdAddr);
    logic [7:0]  d;
    logic [7:0]  lastD;
    logic [15:0] lastA;
    lastD = 8'd0;
    lastA = 16'd0;
    @(negedge clk_sys);
    if (holdCmd) begin
      cmd_wr   = 1'b0;
      cmd_addr = holdAddr;
      cmd_len  = 8'd0;
    end else begin
      cmd_vld = 1'b0;
    end
    checkOutput("wr_busy", 32'(busy), 32'd1);
    for (int i = 0; i <= int'(l); i++) begin
      int gap;
      gap = (i == gapAt) ? gapLen : 0;
      if (maxRandGap > 0) gap += int'($urandom_range(maxRandGap, 0));
      for (int g = 0; g < gap; g++) begin
        wd_vld = 1'b0;
        @(negedge clk_sys);
        checkOutput("wr_gap_fx_wr", 32'(fx_wr), 32'd0);
        checkOutput("wr_gap_cmd_rdy", 32'(cmd_rdy), 32'd0);
        if (i > 0) begin
          checkOutput("wr_gap_waddr_hold", 32'(fx_waddr), 32'(lastA));
          checkOutput("wr_gap_data_hold", 32'(fx_data), 32'(lastD));
        end
      end
      d = (wrData.size() > 0) ? wrData.pop_front() : 8'($urandom);
      wd_vld  = 1'b1;
      wd_data = d;
      checkOutput("wr_wd_rdy", 32'(wd_rdy), 32'd1);
      @(negedge clk_sys);
      lastA = 16'(a + 16'(i));
      lastD = d;
      checkOutput("wr_fx_wr", 32'(fx_wr), 32'd1);
      checkOutput("wr_fx_waddr", 32'(fx_waddr), 32'(lastA));
      checkOutput("wr_fx_data", 32'(fx_data), 32'(d));
      checkOutput("wr_fx_rd_low", 32'(fx_rd), 32'd0);
      checkOutput("wr_cmd_done", 32'(cmd_done), 32'(i == int'(l)));
      checkOutput("wr_cmd_rdy", 32'(cmd_rdy), 32'(i == int'(l)));
    end
    wd_vld = 1'b0;
    if (!holdCmd) begin
      @(negedge clk_sys);
      checkOutput("wr_end_fx_wr", 32'(fx_wr), 32'd0);
      checkOutput("wr_end_cmd_done", 32'(cmd_done), 32'd0);
      checkOutput("wr_end_busy", 32'(busy), 32'd0);
      checkOutput("wr_end_waddr_hold", 32'(fx_waddr), 32'(lastA));
    end
  endtask

  // Called at the cycle fx_rd for beat 0 is expected; walks all read beats.
  task automatic readBeats(input logic [15:0] a, input logic [7:0] l,
                           input int stallFixed, input int maxRandStall);
    logic [15:0] ea;
    logic [7:0]  ed;
    int          n;
    int          s;
    ea = a;
    for (int i = 0; i <= int'(l); i++) begin
      ea = 16'(a + 16'(i));
      ed = slaveByte(ea);
      checkOutput("rd_fx_rd", 32'(fx_rd), 32'd1);
      checkOutput("rd_fx_raddr", 32'(fx_raddr), 32'(ea));
      checkOutput("rd_fx_wr_low", 32'(fx_wr), 32'd0);
      checkOutput("rd_cmd_rdy_low", 32'(cmd_rdy), 32'd0);
      n = 0;
      do begin
        @(negedge clk_sys);
        n++;
      end while (!rd_vld && n < 40);
      checkOutput("rd_latency", 32'(n), 32'(RD_LAT + 1));
      checkOutput("rd_data", 32'(rd_data), 32'(ed));
      s = stallFixed;
      if (maxRandStall > 0) s += int'($urandom_range(maxRandStall, 0));
      for (int k = 0; k < s; k++) begin
        rd_rdy = 1'b0;
        @(negedge clk_sys);
        checkOutput("rd_stall_vld", 32'(rd_vld), 32'd1);
        checkOutput("rd_stall_data", 32'(rd_data), 32'(ed));
      end
      rd_rdy = 1'b1;
      @(negedge clk_sys);
      rd_rdy = 1'b0;
      checkOutput("rd_vld_drop", 32'(rd_vld), 32'd0);
      checkOutput("rd_cmd_done", 32'(cmd_done), 32'(i == int'(l)));
    end
    checkOutput("rd_end_busy", 32'(busy), 32'd0);
    checkOutput("rd_end_fx_rd", 32'(fx_rd), 32'd0);
    checkOutput("rd_end_raddr_hold", 32'(fx_raddr), 32'(ea));
  endtask

  task automatic doWrite(input logic [15:0] a, input logic [7:0] l, input int gapAt,
                         input int gapLen, input int maxRandGap);
    applyStimulus(1'b1, a, l);
    writeBeats(a, l, gapAt, gapLen, maxRandGap, 1'b0, 16'd0);
  endtask

  task automatic doRead(input logic [15:0] a, input logic [7:0] l,
                        input int stallFixed, input int maxRandStall);
    applyStimulus(1'b0, a, l);
    @(negedge clk_sys);
    cmd_vld = 1'b0;
    readBeats(a, l, stallFixed, maxRandStall);
  endtask

  // Safety net so a stuck DUT still ends the run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized commands.
  initial begin
    logic        wr;
    logic [15:0] a;
    logic [7:0]  l;
    int          n;

    $display("[TB] start, RD_LAT=%0d", RD_LAT);
    repeat (3) @(negedge clk_sys);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk_sys);
    checkOutput("post_reset_cmd_rdy", 32'(cmd_rdy), 32'd1);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);

    $display("[TB] single write");
    wrData = '{8'hA5};
    doWrite(16'h0010, 8'd0, -1, 0, 0);

    $display("[TB] burst write with gap");
    wrData = '{8'h11, 8'h22, 8'h33, 8'h44};
    doWrite(16'h0100, 8'd3, 2, 2, 0);

    $display("[TB] burst read with stalls");
    doRead(16'h0200, 8'd1, 3, 0);

    $display("[TB] address wrap");
    doRead(16'hFFFF, 8'd1, 0, 0);

    $display("[TB] busy lockout");
    wrData.delete();
    applyStimulus(1'b1, 16'h0400, 8'd2);
    writeBeats(16'h0400, 8'd2, 1, 3, 0, 1'b1, 16'h0500);
    @(negedge clk_sys);
    cmd_vld = 1'b0;
    readBeats(16'h0500, 8'd0, 0, 0);

    $display("[TB] reset mid-burst");
    applyStimulus(1'b0, 16'h3000, 8'd3);
    @(negedge clk_sys);
    cmd_vld = 1'b0;
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!rd_vld && n < 40);
    checkOutput("rst_beat0_vld", 32'(rd_vld), 32'd1);
    rd_rdy = 1'b1;
    @(negedge clk_sys);
    rd_rdy = 1'b0;
    checkOutput("rst_beat1_fx_rd", 32'(fx_rd), 32'd1);
    checkOutput("rst_beat1_raddr", 32'(fx_raddr), 32'h3001);
    @(negedge clk_sys);
    rst = 1'b1;
    @(negedge clk_sys);
    checkAllZero("midreset");
    rst = 1'b0;
    for (int k = 0; k < RD_LAT + 3; k++) begin
      @(negedge clk_sys);
      checkOutput("after_reset_rd_vld", 32'(rd_vld), 32'd0);
      checkOutput("after_reset_cmd_done", 32'(cmd_done), 32'd0);
      checkOutput("after_reset_cmd_rdy", 32'(cmd_rdy), 32'd1);
    end
    wrData = '{8'h3C};
    doWrite(16'h0777, 8'd0, -1, 0, 0);

    $display("[TB] full 256-beat write across wrap");
    wrData.delete();
    doWrite(16'hFF80, 8'd255, -1, 0, 0);

    $display("[TB] randomized commands");
    for (int r = 0; r < 10; r++) begin
      wr = 1'($urandom_range(1, 0));
      if ($urandom_range(2, 0) == 0) a = 16'(16'hFFFF - 16'($urandom_range(3, 0)));
      else a = 16'($urandom);
      l = 8'($urandom_range(5, 0));
      if (wr) begin
        wrData.delete();
        doWrite(a, l, -1, 0, 2);
      end else begin
        doRead(a, l, 0, 3);
      end
    end

    repeat (2) @(negedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
